// File: rtl/dma_mem_arbiter_pkg.sv
// Shared constants, grant encoding and the beat-address shift helper for the
// DMA memory-port arbiter.
package dma_mem_arbiter_pkg;

  localparam int unsigned DEFAULT_AXI_WIDTH      = 128;
  localparam int unsigned DEFAULT_AXI_ADDR_WIDTH = 32;

  // Byte-to-beat address shift for a beat of the given width in bits.
  function automatic int unsigned calc_lsb(input int unsigned axi_width);
    return $clog2(axi_width) - 3;
  endfunction

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR
  } gnt_e;

endpackage

// File: rtl/dma_mem_arbiter_if.sv
// Request/response and memory-port bundle between the DMA requesters, the
// arbiter (slave modport) and the memory model.
interface dma_mem_arbiter_if
  import dma_mem_arbiter_pkg::*;
#(
  parameter int unsigned AXI_WIDTH      = DEFAULT_AXI_WIDTH,
  parameter int unsigned AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int unsigned LSB            = calc_lsb(AXI_WIDTH)
);
  localparam int unsigned ADDR_W = AXI_ADDR_WIDTH - LSB;
  localparam int unsigned STRB_W = AXI_WIDTH / 8;

  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [ADDR_W-1:0]    rd_req_addr;
  logic                 rd_resp_valid;
  logic                 rd_resp_ready;
  logic [AXI_WIDTH-1:0] rd_resp_data;
  logic                 wr_req_valid;
  logic                 wr_req_ready;
  logic [ADDR_W-1:0]    wr_req_addr;
  logic [AXI_WIDTH-1:0] wr_req_data;
  logic [STRB_W-1:0]    wr_req_strb;
  logic                 mem_ren;
  logic                 mem_wen;
  logic [ADDR_W-1:0]    mem_addr;
  logic [AXI_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]    mem_strb;
  logic [AXI_WIDTH-1:0] mem_rdata;

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_resp_ready,
    input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_strb, mem_rdata,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb
  );

  modport master (
    output rd_req_valid, rd_req_addr, rd_resp_ready,
    output wr_req_valid, wr_req_addr, wr_req_data, wr_req_strb, mem_rdata,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb
  );

endinterface

// File: rtl/dma_arb_resp_fifo.sv
// Two-entry registered read-response FIFO; head reads as zero while empty.
module dma_arb_resp_fifo #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  // When full, a push is only taken alongside a pop: it reuses the slot being drained.
  assign push_ok   = push && ((count_q != 2'd2) || pop);
  assign pop_ok    = pop && (count_q != 2'd0);
  assign head_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency memory port between DMA read
// and write requesters. Optional counters: DMA_MEM_ARBITER_STATS_EN.
module dma_mem_arbiter
  import dma_mem_arbiter_pkg::*;
#(
  parameter int unsigned AXI_WIDTH      = DEFAULT_AXI_WIDTH,
  parameter int unsigned AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int unsigned LSB            = calc_lsb(AXI_WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DMA_MEM_ARBITER_STATS_EN
  output logic [31:0] stat_rd_gnt,
  output logic [31:0] stat_wr_gnt,
  output logic [31:0] stat_conflict,
`endif
  dma_mem_arbiter_if.slave bus
);

  localparam int unsigned ADDR_W = AXI_ADDR_WIDTH - LSB;

  gnt_e              gnt;
  logic              last_gnt_q;  // 0 = read, 1 = write
  logic              last_gnt_d;
  logic              rd_inflight_q;
  logic [1:0]        fifo_count;
  logic              fifo_pop;
  logic              rd_elig;
  logic              wr_elig;
  logic [ADDR_W-1:0] sel_addr;

  assign fifo_pop = bus.rd_resp_valid && bus.rd_resp_ready;

  // Stored beats plus the returning one, less the one leaving now, must leave a free slot.
  assign rd_elig = bus.rd_req_valid &&
                   (({1'b0, fifo_count} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, fifo_pop}));
  assign wr_elig = bus.wr_req_valid;

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (rd_elig && wr_elig) begin
        gnt = last_gnt_q ? GNT_RD : GNT_WR;
      end else if (rd_elig) begin
        gnt = GNT_RD;
      end else if (wr_elig) begin
        gnt = GNT_WR;
      end
    end
  end

  always_comb begin
    last_gnt_d       = last_gnt_q;
    sel_addr         = '0;
    bus.rd_req_ready = 1'b0;
    bus.wr_req_ready = 1'b0;
    bus.mem_ren      = 1'b0;
    bus.mem_wen      = 1'b0;
    bus.mem_wdata    = '0;
    bus.mem_strb     = '0;
    unique case (gnt)
      GNT_RD: begin
        last_gnt_d       = 1'b0;
        sel_addr         = bus.rd_req_addr;
        bus.rd_req_ready = 1'b1;
        bus.mem_ren      = 1'b1;
      end
      GNT_WR: begin
        last_gnt_d       = 1'b1;
        sel_addr         = bus.wr_req_addr;
        bus.wr_req_ready = 1'b1;
        bus.mem_wen      = 1'b1;
        bus.mem_wdata    = bus.wr_req_data;
        bus.mem_strb     = bus.wr_req_strb;
      end
      default: ;
    endcase
    bus.mem_addr = sel_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q    <= 1'b1;
      rd_inflight_q <= 1'b0;
    end else begin
      last_gnt_q    <= last_gnt_d;
      rd_inflight_q <= (gnt == GNT_RD);
    end
  end

  dma_arb_resp_fifo #(
    .WIDTH (AXI_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight_q),
    .push_data (bus.mem_rdata),
    .pop       (fifo_pop),
    .head_data (bus.rd_resp_data),
    .count     (fifo_count)
  );

  assign bus.rd_resp_valid = (fifo_count != 2'd0);

`ifdef DMA_MEM_ARBITER_STATS_EN
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;
  logic [31:0] stat_cf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
      stat_cf_q <= '0;
    end else begin
      if ((gnt == GNT_RD) && (stat_rd_q != '1)) stat_rd_q <= stat_rd_q + 32'd1;
      if ((gnt == GNT_WR) && (stat_wr_q != '1)) stat_wr_q <= stat_wr_q + 32'd1;
      if (rd_elig && wr_elig && (stat_cf_q != '1)) stat_cf_q <= stat_cf_q + 32'd1;
    end
  end

  assign stat_rd_gnt   = stat_rd_q;
  assign stat_wr_gnt   = stat_wr_q;
  assign stat_conflict = stat_cf_q;
`else
  // No statistics counters in this build; arbitration is unchanged.
`endif

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Bench for dma_mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of grants and read responses.
module tb_dma_mem_arbiter;
  import dma_mem_arbiter_pkg::*;

  localparam int unsigned W      = 128;
  localparam int unsigned AW     = 32;
  localparam int unsigned ADDR_W = AW - ($clog2(W) - 3);
  localparam int unsigned SW     = W / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_mem_arbiter_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW)) bus ();

`ifdef DMA_MEM_ARBITER_STATS_EN
  logic [31:0] stat_rd_gnt, stat_wr_gnt, stat_conflict;
`endif

  dma_mem_arbiter #(
    .AXI_WIDTH      (W),
    .AXI_ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef DMA_MEM_ARBITER_STATS_EN
    .stat_rd_gnt   (stat_rd_gnt),
    .stat_wr_gnt   (stat_wr_gnt),
    .stat_conflict (stat_conflict),
`endif
    .bus           (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] beat_of(input int i);
    logic [7:0] b;
    b = 8'(8'h10 + i);
    return {16{b}};
  endfunction

  // Memory seen by the DUT, updated only from its mem_* outputs.
  logic [W-1:0] bmem [16];
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= bmem[bus.mem_addr[3:0]];
    if (bus.mem_wen) begin
      for (int b = 0; b < SW; b++)
        if (bus.mem_strb[b]) bmem[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  // Reference model: shadow memory, owed responses in grant order, and the
  // requester that last won the port.
  logic [W-1:0] shadow [16];
  logic [W-1:0] resp_q [$];
  logic [W-1:0] pend_d;
  bit           pend_v   = 1'b0;
  bit           m_last_w = 1'b1;

  always @(negedge clk) begin
    bit pop, re, we, g_rd, g_wr;
    int outstanding;
    logic [ADDR_W-1:0] exp_addr;
    if (rst) begin
      chk("rst_rd_req_ready", bus.rd_req_ready, '0);
      chk("rst_wr_req_ready", bus.wr_req_ready, '0);
      chk("rst_mem_ren", bus.mem_ren, '0);
      chk("rst_mem_wen", bus.mem_wen, '0);
      chk("rst_mem_addr", bus.mem_addr, '0);
      chk("rst_mem_wdata", bus.mem_wdata, '0);
      chk("rst_mem_strb", bus.mem_strb, '0);
      chk("rst_rd_resp_valid", bus.rd_resp_valid, '0);
      chk("rst_rd_resp_data", bus.rd_resp_data, '0);
      resp_q.delete();
      pend_v   = 1'b0;
      m_last_w = 1'b1;
    end else begin
      pop         = (resp_q.size() != 0) && bus.rd_resp_ready;
      outstanding = resp_q.size() + int'(pend_v) - int'(pop);
      re          = bus.rd_req_valid && (outstanding < 2);
      we          = bus.wr_req_valid;
      // On a tie the side that did not win last time goes.
      g_rd        = re && (!we || m_last_w);
      g_wr        = we && !g_rd;
      exp_addr    = g_rd ? bus.rd_req_addr : (g_wr ? bus.wr_req_addr : '0);
      chk("rd_req_ready", bus.rd_req_ready, g_rd);
      chk("wr_req_ready", bus.wr_req_ready, g_wr);
      chk("mem_ren", bus.mem_ren, g_rd);
      chk("mem_wen", bus.mem_wen, g_wr);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wdata", bus.mem_wdata, g_wr ? bus.wr_req_data : '0);
      chk("mem_strb", bus.mem_strb, g_wr ? bus.wr_req_strb : '0);
      chk("rd_resp_valid", bus.rd_resp_valid, resp_q.size() != 0);
      if (resp_q.size() != 0) chk("rd_resp_data", bus.rd_resp_data, resp_q[0]);
      chk("fifo_count_le2", dut.u_fifo.count_q <= 2'd2, 1'b1);
      if (pop) void'(resp_q.pop_front());
      if (pend_v) resp_q.push_back(pend_d);
      pend_v = g_rd;
      if (g_rd) pend_d = shadow[bus.rd_req_addr[3:0]];
      if (g_wr) begin
        for (int b = 0; b < SW; b++)
          if (bus.wr_req_strb[b]) shadow[bus.wr_req_addr[3:0]][8*b +: 8] = bus.wr_req_data[8*b +: 8];
      end
      if (g_rd || g_wr) m_last_w = g_wr;
    end
  end

  // Per-cycle samples taken by tick() just before the clock edge.
  bit           s_rgnt, s_wgnt, s_ren, s_wen, s_valid;
  logic [W-1:0] got_q [$];
  int           got_cyc [$];
  int           cyc;

  task automatic drive(input bit rv, input int ra, input bit rr, input bit wv, input int wa,
                       input logic [W-1:0] wd, input logic [SW-1:0] ws);
    bus.rd_req_valid  = rv;
    bus.rd_req_addr   = ADDR_W'(ra);
    bus.rd_resp_ready = rr;
    bus.wr_req_valid  = wv;
    bus.wr_req_addr   = ADDR_W'(wa);
    bus.wr_req_data   = wd;
    bus.wr_req_strb   = ws;
  endtask

  task automatic tick();
    #1;
    s_rgnt  = bus.rd_req_ready;
    s_wgnt  = bus.wr_req_ready;
    s_ren   = bus.mem_ren;
    s_wen   = bus.mem_wen;
    s_valid = bus.rd_resp_valid;
    if (bus.rd_resp_valid && bus.rd_resp_ready) begin
      got_q.push_back(bus.rd_resp_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_r, n_w, n_tail;
    int exp4 [6];
    exp4 = '{0, 2, 4, 5, 6, 7};
    for (int i = 0; i < 16; i++) begin
      bmem[i]   = beat_of(i);
      shadow[i] = beat_of(i);
    end
    cyc = 0;
    rst = 1'b1;
    // Requests held during reset must not be granted.
    drive(1, 1, 1, 1, 2, rnd_beat(), '1);
    #1;
    chk("reset_rd_ready", bus.rd_req_ready, '0);
    chk("reset_wr_ready", bus.wr_req_ready, '0);
    chk("reset_ren_wen", {bus.mem_ren, bus.mem_wen}, '0);
    chk("reset_resp_valid", bus.rd_resp_valid, '0);
    tick();
    do_reset();

    // Back-to-back reads of addresses 0..7.
    cyc = 0; got_q.delete(); got_cyc.delete(); n_r = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 1, 0, 0, '0, '0);
      tick();
      if (s_rgnt && s_ren) n_r++;
    end
    drive(0, 0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 6 && got_q.size() < 8; i++) tick();
    chk("p1_read_grants", n_r, 8);
    chk("p1_beats", got_q.size(), 8);
    if (got_q.size() != 0) chk("p1_first_latency", got_cyc[0], 2);
    for (int i = 0; i < got_q.size(); i++) chk("p1_beat", got_q[i], beat_of(i));

    // Saturated conflict straight out of reset: strict alternation starting with read.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, i % 8, 1, 1, 8 + (i % 8), rnd_beat(), '1);
      tick();
      chk("p2_rd_turn", s_rgnt, (i % 2) == 0);
      chk("p2_wr_turn", s_wgnt, (i % 2) == 1);
      chk("p2_not_both", s_ren && s_wen, 1'b0);
    end
`ifdef DMA_MEM_ARBITER_STATS_EN
    chk("p2_stat_rd_gnt", stat_rd_gnt, 32'd5);
    chk("p2_stat_wr_gnt", stat_wr_gnt, 32'd5);
    chk("p2_stat_conflict", stat_conflict, 32'd10);
`endif
    drive(0, 0, 1, 0, 0, '0, '0);
    repeat (4) tick();

    // Read-before-write, partial write, read-after-write on address 3.
    got_q.delete();
    drive(1, 3, 1, 0, 0, '0, '0);
    tick();
    chk("p3_read_old_gnt", s_rgnt, 1'b1);
    drive(0, 0, 1, 1, 3, {16{8'hA5}}, 16'h00FF);
    tick();
    chk("p3_write_gnt", s_wgnt, 1'b1);
    drive(1, 3, 1, 0, 0, '0, '0);
    tick();
    drive(0, 0, 1, 0, 0, '0, '0);
    repeat (4) tick();
    chk("p3_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("p3_old_beat", got_q[0], 128'h13131313_13131313_13131313_13131313);
      chk("p3_merged_beat", got_q[1], 128'h13131313_13131313_A5A5A5A5_A5A5A5A5);
    end

    // Response backpressure: two reads fill the buffer, writes keep flowing.
    do_reset();
    got_q.delete(); n_r = 0; n_w = 0; n_tail = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 0, 1, 12, rnd_beat(), '1);
      tick();
      if (s_rgnt) n_r++;
      if (s_wgnt) n_w++;
      if (s_wgnt && i >= 4) n_tail++;
    end
    chk("p4_reads_while_stalled", n_r, 2);
    chk("p4_writes_while_stalled", n_w, 6);
    chk("p4_writes_every_cycle_tail", n_tail, 4);
    chk("p4_rd_ready_low", s_rgnt, 1'b0);
    chk("p4_resp_valid_held", s_valid, 1'b1);
    for (int i = 4; i < 8; i++) begin
      drive(1, i, 1, 0, 0, '0, '0);
      tick();
    end
    drive(0, 0, 1, 0, 0, '0, '0);
    repeat (6) tick();
    chk("p4_beats", got_q.size(), 6);
    for (int i = 0; i < got_q.size() && i < 6; i++) chk("p4_beat", got_q[i], beat_of(exp4[i]));

    // Reset with one beat buffered and one read in flight.
    do_reset();
    drive(1, 1, 0, 0, 0, '0, '0);
    tick();
    drive(1, 2, 0, 0, 0, '0, '0);
    tick();
    chk("p5_count_before_rst", dut.u_fifo.count_q, 2'd1);
    rst = 1'b1;
    drive(1, 4, 1, 1, 5, rnd_beat(), '1);
    #1;
    chk("p5_rst_ready", {bus.rd_req_ready, bus.wr_req_ready}, '0);
    chk("p5_rst_mem", {bus.mem_ren, bus.mem_wen, bus.mem_addr}, '0);
    chk("p5_rst_resp", {bus.rd_resp_valid, bus.rd_resp_data}, '0);
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
    drive(0, 0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p5_no_stale_resp", s_valid, 1'b0);
    end
    drive(1, 5, 1, 0, 0, '0, '0);
    tick();
    drive(0, 0, 1, 0, 0, '0, '0);
    repeat (4) tick();
    chk("p5_beats", got_q.size(), 1);
    if (got_q.size() == 1) chk("p5_beat", got_q[0], beat_of(5));

    // Randomized traffic; the negedge model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom % 16, ($urandom % 3) != 0,
            ($urandom % 2) != 0, $urandom % 16, rnd_beat(), SW'($urandom));
      tick();
    end
    drive(0, 0, 1, 0, 0, '0, '0);
    repeat (6) tick();
    chk("drain_empty", bus.rd_resp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
